// File: rtl/dmem_requester.sv
// Load/store requester: turns one pipeline memory request into a single aligned
// 64-bit memory access, with byte lanes, load extension and activity counters.
module dmem_requester #(
   parameter int DMEM_ADDRESS_WIDTH = 20
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_valid,
   input  logic                          req_write,
   input  logic [DMEM_ADDRESS_WIDTH-1:0] req_addr,
   input  logic [1:0]                    req_size,
   input  logic                          req_signed,
   input  logic [63:0]                   req_wdata,
   output logic                          stall,
   output logic                          rsp_valid,
   output logic [63:0]                   rsp_rdata,
   output logic                          misalign_err,
   output logic [DMEM_ADDRESS_WIDTH-1:0] address,
   output logic [63:0]                   data_in,
   output logic [7:0]                    bytemask,
   output logic                          write,
   output logic                          start_access,
   input  logic                          access_done,
   input  logic [63:0]                   data_out,
   output logic [31:0]                   access_count,
   output logic [31:0]                   busy_cycles,
   output logic [1:0]                    dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

   state_e                        state_q, state_d;
   logic [DMEM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]                    size_q, size_d;
   logic                          write_q, write_d;
   logic                          signed_q, signed_d;
   logic [63:0]                   wdata_q, wdata_d;
   logic [63:0]                   rdata_q, rdata_d;
   logic [31:0]                   count_q, count_d;
   logic [31:0]                   busy_q, busy_d;

   logic       aligned;
   logic [2:0] offset;
   logic [7:0] size_mask;
   logic [63:0] shifted;
   logic       in_busy;
   logic       in_resp;

   always_comb begin
      case (req_size)
         2'd0:    aligned = 1'b1;
         2'd1:    aligned = ~req_addr[0];
         2'd2:    aligned = (req_addr[1:0] == 2'b00);
         default: aligned = (req_addr[2:0] == 3'b000);
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      size_d       = size_q;
      write_d      = write_q;
      signed_d     = signed_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      count_d      = count_q;
      busy_d       = busy_q;
      stall        = 1'b0;
      rsp_valid    = 1'b0;
      misalign_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (aligned) begin
                  addr_d   = req_addr;
                  size_d   = req_size;
                  write_d  = req_write;
                  signed_d = req_signed;
                  wdata_d  = req_wdata;
                  stall    = 1'b1;
                  state_d  = BUSY;
               end else begin
                  misalign_err = 1'b1;
                  rsp_valid    = 1'b1;
               end
            end
         end
         BUSY: begin
            stall  = 1'b1;
            busy_d = busy_q + 32'd1;
            if (access_done) begin
               rdata_d = data_out;
               count_d = count_q + 32'd1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset overrides whatever the current state would present this cycle.
      if (reset) begin
         stall        = 1'b0;
         rsp_valid    = 1'b0;
         misalign_err = 1'b0;
      end
   end

   // Command and response paths read only latched request state.
   always_comb begin
      in_busy = (state_q == BUSY) && !reset;
      in_resp = (state_q == RESP) && !reset;
      offset  = addr_q[2:0];
      case (size_q)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
      shifted      = rdata_q >> {offset, 3'b000};
      start_access = in_busy;
      write        = in_busy & write_q;
      address      = in_busy ? {addr_q[DMEM_ADDRESS_WIDTH-1:3], 3'b000} : '0;
      data_in      = in_busy ? (wdata_q << {offset, 3'b000}) : 64'd0;
      bytemask     = in_busy ? (size_mask << offset) : 8'd0;
      rsp_rdata    = 64'd0;
      if (in_resp && !write_q) begin
         case (size_q)
            2'd0:    rsp_rdata = {{56{signed_q & shifted[7]}},  shifted[7:0]};
            2'd1:    rsp_rdata = {{48{signed_q & shifted[15]}}, shifted[15:0]};
            2'd2:    rsp_rdata = {{32{signed_q & shifted[31]}}, shifted[31:0]};
            default: rsp_rdata = shifted;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         size_q   <= 2'd0;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         wdata_q  <= 64'd0;
         rdata_q  <= 64'd0;
         count_q  <= 32'd0;
         busy_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

   assign access_count = count_q;
   assign busy_cycles  = busy_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_requester.sv
// Bench for dmem_requester: a cycle-stepped memory responder plus an expected
// load-data queue checked whenever the requester pulses rsp_valid.
module tb_dmem_requester;

   localparam int W = 20;

   logic          clk;
   logic          reset;
   logic          req_valid;
   logic          req_write;
   logic [W-1:0]  req_addr;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [63:0]   req_wdata;
   logic          stall;
   logic          rsp_valid;
   logic [63:0]   rsp_rdata;
   logic          misalign_err;
   logic [W-1:0]  address;
   logic [63:0]   data_in;
   logic [7:0]    bytemask;
   logic          write;
   logic          start_access;
   logic          access_done;
   logic [63:0]   data_out;
   logic [31:0]   access_count;
   logic [31:0]   busy_cycles;
   logic [1:0]    dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_count = 0;
   logic [31:0] exp_busy  = 0;
   logic [63:0] exp_q[$];

   dmem_requester #(.DMEM_ADDRESS_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
      .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .misalign_err(misalign_err), .address(address),
      .data_in(data_in), .bytemask(bytemask), .write(write),
      .start_access(start_access), .access_done(access_done), .data_out(data_out),
      .access_count(access_count), .busy_cycles(busy_cycles), .dbg_state(dbg_state)
   );

   // Clock and reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model_rdata(input logic wr, input logic [2:0] off,
                                               input logic [1:0] sz, input logic sg,
                                               input logic [63:0] md);
      logic [63:0] sh;
      logic [63:0] r;
      sh = md >> (8 * off);
      case (sz)
         2'd0:    r = sg ? {{56{sh[7]}}, sh[7:0]}   : {56'd0, sh[7:0]};
         2'd1:    r = sg ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
         2'd2:    r = sg ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
         default: r = sh;
      endcase
      return wr ? 64'd0 : r;
   endfunction

   task automatic check_quiet(input string name);
      checks++;
      if ({start_access, stall, rsp_valid, misalign_err} !== 4'b0000) begin
         errors++;
         $display("FAIL %s ctrl: got %b expected 0000", name,
                  {start_access, stall, rsp_valid, misalign_err});
      end
      checks++;
      if ({rsp_rdata, address, data_in, bytemask} !== '0) begin
         errors++;
         $display("FAIL %s data: rdata=%h addr=%h din=%h mask=%h expected all zero",
                  name, rsp_rdata, address, data_in, bytemask);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = 2'd0;
      req_signed = 1'b0; req_wdata = 64'd0; access_done = 1'b0; data_out = 64'd0;
      repeat (2) @(negedge clk);
      #1 check_quiet("reset_during");
      @(negedge clk);
      reset = 1'b0;
      #1 check_quiet("reset_after");
      checks++;
      if (access_count !== 32'd0 || busy_cycles !== 32'd0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_counters: got cnt=%0d busy=%0d st=%0d expected 0 0 0",
                  access_count, busy_cycles, dbg_state);
      end
      exp_count = 0;
      exp_busy  = 0;
   endtask

   // Issues one aligned request and plays memory with the given latency.
   task automatic do_access(input logic wr, input logic [W-1:0] a, input logic [1:0] sz,
                            input logic sg, input logic [63:0] wd, input logic [63:0] md,
                            input int lat);
      logic [W-1:0] e_addr;
      logic [7:0]   e_mask;
      logic [63:0]  e_din;
      logic [63:0]  e_rd;
      logic [7:0]   m;
      int busy_n;
      bit done;
      m = (sz == 2'd0) ? 8'h01 : (sz == 2'd1) ? 8'h03 : (sz == 2'd2) ? 8'h0F : 8'hFF;
      e_addr = {a[W-1:3], 3'b000};
      e_mask = m << a[2:0];
      e_din  = wd << (8 * a[2:0]);
      exp_q.push_back(model_rdata(wr, a[2:0], sz, sg, md));
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
      req_signed = sg; req_wdata = wd; data_out = md;
      #1;
      checks++;
      if (stall !== 1'b1 || start_access !== 1'b0 || rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL accept: got stall=%b start=%b rsp=%b st=%0d expected 1 0 0 0",
                  stall, start_access, rsp_valid, dbg_state);
      end
      busy_n = 0;
      done   = 1'b0;
      for (int c = 0; c < lat + 8 && !done; c++) begin
         @(negedge clk);
         #1;
         if (start_access) begin
            checks++;
            if (address !== e_addr || bytemask !== e_mask || data_in !== e_din ||
                write !== wr || stall !== 1'b1) begin
               errors++;
               $display("FAIL busy_cmd: got addr=%h mask=%h din=%h wr=%b stall=%b expected %h %h %h %b 1",
                        address, bytemask, data_in, write, stall, e_addr, e_mask, e_din, wr);
            end
            access_done = (busy_n == lat);
            busy_n++;
         end else if (rsp_valid) begin
            done = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_rdata: got %h expected no response", rsp_rdata);
            end else begin
               e_rd = exp_q.pop_front();
               if (rsp_rdata !== e_rd || stall !== 1'b0) begin
                  errors++;
                  $display("FAIL rsp_rdata: got %h stall=%b expected %h stall=0",
                           rsp_rdata, stall, e_rd);
               end
            end
            exp_count = exp_count + 32'd1;
            exp_busy  = exp_busy + 32'(lat + 1);
            checks++;
            if (access_count !== exp_count || busy_cycles !== exp_busy) begin
               errors++;
               $display("FAIL counters: got cnt=%0d busy=%0d expected %0d %0d",
                        access_count, busy_cycles, exp_count, exp_busy);
            end
            access_done = 1'b0;
            req_valid   = 1'b0;
         end else begin
            checks++;
            errors++;
            $display("FAIL idle_gap: got st=%0d expected BUSY or RESP", dbg_state);
            done = 1'b1;
         end
      end
      checks++;
      if (!done || busy_n != lat + 1) begin
         errors++;
         $display("FAIL latency: got busy_n=%0d done=%0d expected %0d 1", busy_n, done, lat + 1);
         access_done = 1'b0;
         req_valid   = 1'b0;
      end
   endtask

   task automatic test_load_dword();
      do_access(1'b0, 20'h00040, 2'd3, 1'b0, 64'd0, 64'h1122334455667788, 3);
   endtask

   task automatic test_store_byte();
      do_access(1'b1, 20'h00013, 2'd0, 1'b0, 64'hAB, 64'hDEADBEEFCAFEF00D, 2);
   endtask

   task automatic test_half_extend();
      do_access(1'b0, 20'h00006, 2'd1, 1'b1, 64'd0, 64'h8001_0000_0000_0000, 1);
      do_access(1'b0, 20'h00006, 2'd1, 1'b0, 64'd0, 64'h8001_0000_0000_0000, 0);
      do_access(1'b0, 20'h00005, 2'd0, 1'b1, 64'd0, 64'h0000_F000_0000_0000, 2);
      do_access(1'b0, 20'h00104, 2'd2, 1'b1, 64'd0, 64'h9ABC_DEF0_0000_0000, 1);
   endtask

   task automatic test_misalign();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00002; req_size = 2'd2;
      #1;
      checks++;
      if (misalign_err !== 1'b1 || rsp_valid !== 1'b1 || stall !== 1'b0 || start_access !== 1'b0) begin
         errors++;
         $display("FAIL misalign_pulse: got err=%b rsp=%b stall=%b start=%b expected 1 1 0 0",
                  misalign_err, rsp_valid, stall, start_access);
      end
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checks++;
      if (misalign_err !== 1'b0 || start_access !== 1'b0 || dbg_state !== 2'd0 ||
          access_count !== exp_count) begin
         errors++;
         $display("FAIL misalign_after: got err=%b start=%b st=%0d cnt=%0d expected 0 0 0 %0d",
                  misalign_err, start_access, dbg_state, access_count, exp_count);
      end
   endtask

   task automatic test_done_ignored();
      @(negedge clk);
      access_done = 1'b1;
      repeat (2) @(negedge clk);
      access_done = 1'b0;
      #1;
      checks++;
      if (access_count !== exp_count || dbg_state !== 2'd0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL done_ignored: got cnt=%0d st=%0d rsp=%b expected %0d 0 0",
                  access_count, dbg_state, rsp_valid, exp_count);
      end
   endtask

   task automatic test_reset_in_busy();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00080; req_size = 2'd3;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; req_valid = 1'b0;
      #1;
      checks++;
      if (start_access !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_during: got start=%b rsp=%b expected 0 0", start_access, rsp_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_count = 0;
      exp_busy  = 0;
      #1;
      checks++;
      if (dbg_state !== 2'd0 || start_access !== 1'b0 || rsp_valid !== 1'b0 || access_count !== 32'd0) begin
         errors++;
         $display("FAIL rst_busy_after: got st=%0d start=%b rsp=%b cnt=%0d expected 0 0 0 0",
                  dbg_state, start_access, rsp_valid, access_count);
      end
      do_access(1'b0, 20'h00088, 2'd2, 1'b0, 64'd0, 64'h0123_4567_89AB_CDEF, 2);
   endtask

   task automatic test_back_to_back();
      test_reset();
      do_access(1'b0, 20'h00200, 2'd3, 1'b0, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0, 5);
      do_access(1'b0, 20'h00208, 2'd3, 1'b0, 64'd0, 64'h0102_0304_0506_0708, 5);
      checks++;
      if (busy_cycles !== 32'd12 || access_count !== 32'd2) begin
         errors++;
         $display("FAIL back_to_back: got busy=%0d cnt=%0d expected 12 2", busy_cycles, access_count);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         logic [1:0]   sz;
         logic [W-1:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = W'($urandom_range(0, 20'hFFFFF));
         a  = a & ~W'((1 << sz) - 1);
         do_access(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 4));
      end
   endtask

   initial begin
      test_reset();
      test_load_dword();
      test_store_byte();
      test_half_extend();
      test_misalign();
      test_done_ignored();
      test_reset_in_busy();
      test_back_to_back();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
